// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Packet-granular round-robin arbiter that shares the write port of one wide
// FWFT FIFO between NREQ requesters. The FIFO stays locked to one requester
// from its grant until its LAST word is accepted, so packets never interleave.
// The write enable and data are registered. REQ_READY is built from the state
// register and FIFO_BP only, so there is no REQ_VALID -> REQ_READY path.

module fifo_wr_arbiter #(
    parameter  int NREQ = 4,
    parameter  int W    = 512,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ_VALID,
    input  logic [NREQ-1:0][W-1:0]  REQ_D,
    input  logic [NREQ-1:0]         REQ_LAST,
    output logic [NREQ-1:0]         REQ_READY,
    input  logic                    FIFO_BP,
    output logic                    FIFO_WR_EN,
    output logic [W-1:0]            FIFO_D,
    output logic [PW-1:0]           CUR_OWNER,
    output logic                    BUSY
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_nxt_s;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   owner_nxt_s;
    logic [PW-1:0]   pick_s;
    logic [NREQ-1:0] ready_s;
    logic            transfer_s;
    logic            fifo_wr_en_r;
    logic [W-1:0]    fifo_d_r;

    // Increment an owner index, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        if (v == PW'(NREQ - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = v + PW'(1);
        end
        return r;
    endfunction

    // First valid requester scanning upward from ptr, modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] idx;
        logic [PW-1:0] pick;
        logic          found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
            idx = inc_mod(idx);
        end
        return pick;
    endfunction

    assign pick_s = rr_pick(REQ_VALID, ptr_r);

    // Per-requester ready and the owner's transfer qualifier.
    always_comb begin
        ready_s    = {NREQ{1'b0}};
        transfer_s = 1'b0;
        if ((state_r == ST_LOCKED) && !FIFO_BP) begin
            ready_s[owner_r] = 1'b1;
            transfer_s       = REQ_VALID[owner_r];
        end else begin
            ready_s    = {NREQ{1'b0}};
            transfer_s = 1'b0;
        end
    end

    // Next-state logic: grant in IDLE, release on the owner's LAST transfer.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (!FIFO_BP && (|REQ_VALID)) begin
                    state_nxt_s = ST_LOCKED;
                    owner_nxt_s = pick_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (transfer_s && REQ_LAST[owner_r]) begin
                    state_nxt_s = ST_IDLE;
                    ptr_nxt_s   = inc_mod(owner_r);
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, rotation pointer and owner registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PW{1'b0}};
            owner_r <= {PW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Registered FIFO write port; data holds between writes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_wr_en_r <= 1'b0;
            fifo_d_r     <= {W{1'b0}};
        end else begin
            fifo_wr_en_r <= transfer_s;
            if (transfer_s) begin
                fifo_d_r <= REQ_D[owner_r];
            end else begin
                fifo_d_r <= fifo_d_r;
            end
        end
    end

    assign REQ_READY  = ready_s;
    assign FIFO_WR_EN = fifo_wr_en_r;
    assign FIFO_D     = fifo_d_r;
    assign CUR_OWNER  = owner_r;
    assign BUSY       = (state_r == ST_LOCKED);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Packet-granular round-robin arbiter that shares the write port of one wide synchronous FWFT FIFO (512-bit words, prog_full backpressure) between NREQ upstream requesters. It locks the FIFO to one requester from grant until that requester's LAST word, so packets never interleave. It registers write enable and data into the FIFO, and converts the FIFO's prog_full into per-requester ready.

## Interface
- NREQ, 4: number of requesters, 2..16.
- W, 512: data word width, equal to the FIFO WRITE_DATA_WIDTH.
- PW, $clog2(NREQ): owner index width (derived).
- CLK  in  1  the single clock.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  NREQ  per-requester word valid.
- REQ_D  in  NREQ×W  per-requester word, packed [NREQ-1:0][W-1:0].
- REQ_LAST  in  NREQ  marks the final word of a packet; qualified by valid.
- REQ_READY  out  NREQ  per-requester accept; at most one bit high.
- FIFO_BP  in  1  FIFO prog_full; 1 = stop writing.
- FIFO_WR_EN  out  1  registered FIFO write enable.
- FIFO_D  out  W  registered FIFO write data.
- CUR_OWNER  out  PW  index of the locked or last-granted requester.
- BUSY  out  1  1 while in LOCKED.

## Operation
- State machine with two states:
  - IDLE → LOCKED: FIFO_BP=0 and any REQ_VALID=1. The owner is the first requester with valid, scanning from PTR upward modulo NREQ.
  - LOCKED → IDLE: a transfer with REQ_LAST[owner]=1. PTR becomes (owner+1) mod NREQ.
  - LOCKED holds otherwise, including when the owner's valid drops mid-packet or FIFO_BP is asserted. There is no timeout and no preemption.
- REQ_READY[i] = (state==LOCKED) && (owner==i) && !FIFO_BP. This is combinational from state and FIFO_BP. No REQ_VALID→REQ_READY path exists.
- Transfer: REQ_VALID[owner] && REQ_READY[owner].
- Output stage, every cycle:
  - FIFO_WR_EN <= transfer.
  - FIFO_D <= REQ_D[owner] on a transfer; otherwise FIFO_D holds its value.
- CUR_OWNER is loaded at grant and holds through IDLE.
- Requesters must hold REQ_D, REQ_LAST and REQ_VALID stable until accepted.
- The FIFO's PROG_FULL_THRESH must leave at least 2 words of headroom below full. This absorbs the one registered write in flight when FIFO_BP rises.
- In IDLE with FIFO_BP=1, no grant is made even if requests are pending.
- Reset values: state IDLE, PTR=0, CUR_OWNER=0, FIFO_WR_EN=0, FIFO_D=0, BUSY=0, REQ_READY=0.

## Timing
- Grant: IDLE samples a request in cycle n. The block is LOCKED in n+1, where REQ_READY can be high.
- Write latency: a word accepted in cycle m appears as FIFO_WR_EN=1 with FIFO_D in cycle m+1.
- Throughput:
  - Within a packet, one word per cycle while valid=1 and FIFO_BP=0.
  - Each packet costs one arbitration (IDLE) cycle, so 1-word packets run at 50% peak.
- FIFO_BP rising in cycle k: REQ_READY is low in cycle k. At most one write (accepted in k-1) still lands in k.
- Simultaneous LAST and another requester's valid: the other requester is granted in the following IDLE cycle. Rotation uses the updated PTR.
- RST is asynchronous: all registers clear immediately and outputs go to their reset values in the same cycle. A packet in progress is abandoned with no FIFO write. Deassertion is synchronous to CLK; the first grant can occur in the first edge after release.

## Test plan
- Reset: assert RST with requests pending → REQ_READY=0, FIFO_WR_EN=0, FIFO_D=0, CUR_OWNER=0, BUSY=0 throughout. After release, req0 with valid is granted one cycle later.
- Single packet: req1 sends words A,B,C with LAST on C, FIFO_BP=0 → CUR_OWNER=1, REQ_READY[1] high for 3 cycles. FIFO_WR_EN=1 for 3 consecutive cycles with FIFO_D=A,B,C, one cycle after each accept. BUSY drops after C.
- Round robin: all 4 requesters continuously offer 2-word packets → grant order 0,1,2,3,0,1. Each packet is 2 contiguous writes, with exactly one idle cycle between packets.
- Backpressure: FIFO_BP=1 for 5 cycles mid-packet of req2 → REQ_READY[2]=0 in those cycles. At most one write occurs in the first BP cycle, and no writes after it. The remaining words resume after BP=0, with no other owner in between.
- No preemption: req2 valid gaps for 4 cycles mid-packet while req3 requests → state stays LOCKED with owner 2 and req3 is not granted. req3 is granted only after req2's LAST.
- Async reset mid-packet: RST asserted between edges during req0 word 2 of 4 → outputs clear immediately and PTR=0. After release, the first grant goes to the lowest-index valid requester.
